// File: rtl/hdc_sched_pkg.sv
// Shared types and default widths for the HDC search scheduler.
// The scan FSM state encoding and the stream tag layout live here.
package hdc_sched_pkg;

    localparam int unsigned DefDataW      = 64;
    localparam int unsigned DefNumClasses = 8;
    localparam int unsigned DefNumFrames  = 3;
    localparam int unsigned DefClassIdW   = $clog2(DefNumClasses);
    localparam int unsigned DefFrameIdxW  = $clog2(DefNumFrames);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } scan_state_t;

    typedef struct packed {
        logic [DefClassIdW-1:0]  class_id;
        logic [DefFrameIdxW-1:0] frame_index;
        logic                    class_last;
        logic                    scan_last;
    } scan_tag_t;

endpackage

// File: rtl/hvec_stream_reg.sv
// One-entry valid/ready output register. A load is legal whenever the entry is
// empty or is being accepted in the same cycle; flush empties it unconditionally.
module hvec_stream_reg #(
    parameter int unsigned DataW = 64,
    parameter int unsigned TagW  = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic [DataW-1:0] data_i,
    input  logic [TagW-1:0]  tag_i,
    output logic             load_ready_o,
    output logic [DataW-1:0] data_o,
    output logic [TagW-1:0]  tag_o,
    output logic             valid_o,
    input  logic             ready_i
);

    logic             valid_q, valid_d;
    logic [DataW-1:0] data_q, data_d;
    logic [TagW-1:0]  tag_q, tag_d;

    assign load_ready_o = !valid_q || ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        tag_d   = tag_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            tag_d   = tag_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
        end
    end

    assign data_o  = data_q;
    assign tag_o   = tag_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/class_hvec_scan_ctrl.sv
// Walks the class hypervector memory frame by frame and streams each frame out
// with class/frame tags. Counters sit at (0,0) whenever the FSM is idle.
module class_hvec_scan_ctrl
    import hdc_sched_pkg::*;
#(
    parameter int unsigned DI_PARALLEL_W_BITS = DefDataW,
    parameter int unsigned NUM_CLASSES        = DefNumClasses,
    parameter int unsigned NUM_FRAMES         = DefNumFrames,
    parameter int unsigned CLASS_ID_W         = $clog2(NUM_CLASSES),
    parameter int unsigned FRAME_IDX_W        = $clog2(NUM_FRAMES)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [CLASS_ID_W-1:0]         class_limit,
    output logic                          busy,
    output logic                          done,
    output logic [CLASS_ID_W-1:0]         frame_id,
    output logic [FRAME_IDX_W-1:0]        frame_index,
    input  logic [DI_PARALLEL_W_BITS-1:0] class_vec_in,
    output logic [DI_PARALLEL_W_BITS-1:0] out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CLASS_ID_W-1:0]         out_class_id,
    output logic [FRAME_IDX_W-1:0]        out_frame_index,
    output logic                          out_class_last,
    output logic                          out_scan_last
);

    scan_state_t             state_q, state_d;
    logic [CLASS_ID_W-1:0]   cls_q, cls_d;
    logic [FRAME_IDX_W-1:0]  frm_q, frm_d;
    logic [CLASS_ID_W-1:0]   limit_q, limit_d;
    logic                    done_q, done_d;

    logic                    load;
    logic                    flush;
    logic                    load_ready;
    logic                    last_frm;
    logic                    last_load;
    logic [CLASS_ID_W-1:0]   limit_clamped;
    logic [CLASS_ID_W-1:0]   cur_limit;
    scan_tag_t               tag_in;
    scan_tag_t               tag_out;

    always_comb begin
        limit_clamped = class_limit;
        if (32'(class_limit) >= NUM_CLASSES) begin
            limit_clamped = CLASS_ID_W'(NUM_CLASSES - 1);
        end
    end

    // The first frame loads in the start cycle, before limit_q holds the new limit.
    assign cur_limit = (state_q == StIdle) ? limit_clamped : limit_q;
    assign last_frm  = (frm_q == FRAME_IDX_W'(NUM_FRAMES - 1));
    assign last_load = last_frm && (cls_q == cur_limit);

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        frm_d   = frm_q;
        limit_d = limit_q;
        done_d  = 1'b0;
        load    = 1'b0;
        flush   = 1'b0;

        if (abort) begin
            state_d = StIdle;
            cls_d   = '0;
            frm_d   = '0;
            flush   = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        limit_d = limit_clamped;
                        load    = 1'b1;
                    end
                end
                StRun: begin
                    load = load_ready;
                end
                StDrain: begin
                    if (out_valid && out_ready) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase

            if (load) begin
                if (last_load) begin
                    cls_d   = '0;
                    frm_d   = '0;
                    state_d = StDrain;
                end else if (last_frm) begin
                    cls_d   = cls_q + CLASS_ID_W'(1);
                    frm_d   = '0;
                    state_d = StRun;
                end else begin
                    frm_d   = frm_q + FRAME_IDX_W'(1);
                    state_d = StRun;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cls_q   <= '0;
            frm_q   <= '0;
            limit_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            frm_q   <= frm_d;
            limit_q <= limit_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        tag_in             = '0;
        tag_in.class_id    = cls_q;
        tag_in.frame_index = frm_q;
        tag_in.class_last  = last_frm;
        tag_in.scan_last   = last_load;
    end

    hvec_stream_reg #(
        .DataW (DI_PARALLEL_W_BITS),
        .TagW  ($bits(scan_tag_t))
    ) u_stream_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush),
        .load_i       (load),
        .data_i       (class_vec_in),
        .tag_i        (tag_in),
        .load_ready_o (load_ready),
        .data_o       (out_data),
        .tag_o        (tag_out),
        .valid_o      (out_valid),
        .ready_i      (out_ready)
    );

    assign busy            = (state_q != StIdle);
    assign done            = done_q;
    assign frame_id        = cls_q;
    assign frame_index     = frm_q;
    assign out_class_id    = tag_out.class_id;
    assign out_frame_index = tag_out.frame_index;
    assign out_class_last  = tag_out.class_last;
    assign out_scan_last   = tag_out.scan_last;

endmodule

// File: tb/tb_class_hvec_scan_ctrl.sv
// Scoreboard bench for class_hvec_scan_ctrl: expected beats are queued when a
// scan is started and popped as the DUT hands them off.
module tb_class_hvec_scan_ctrl;

    localparam int NumClasses   = 8;
    localparam int NumFrames    = 3;
    localparam int ClsW         = 3;
    localparam int FrmW         = 2;
    localparam int ClampClasses = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic            start, abort, busy, done, out_valid, out_ready;
    logic [ClsW-1:0] class_limit, frame_id, out_class_id;
    logic [FrmW-1:0] frame_index, out_frame_index;
    logic [63:0]     class_vec_in, out_data;
    logic            out_class_last, out_scan_last;

    logic            cl_start, cl_abort, cl_busy, cl_done, cl_out_valid, cl_out_ready;
    logic [ClsW-1:0] cl_class_limit, cl_frame_id, cl_out_class_id;
    logic [FrmW-1:0] cl_frame_index, cl_out_frame_index;
    logic [63:0]     cl_class_vec_in, cl_out_data;
    logic            cl_out_class_last, cl_out_scan_last;

    typedef struct packed {
        logic [63:0]     data;
        logic [ClsW-1:0] cls;
        logic [FrmW-1:0] frm;
        logic            cl;
        logic            sl;
    } beat_t;

    beat_t sb_q[$];
    int    n_vec  = 0;
    int    n_miss = 0;

    function automatic logic [63:0] mem_word(input logic [ClsW-1:0] c, input logic [FrmW-1:0] f);
        return {4'hA, 1'b0, c, 4'h5, 2'b00, f,
                16'h1234 + 16'(c) * 16'd7 + 16'(f),
                32'hDEAD_BEEF ^ (32'(c) * 32'd131 + 32'(f) * 32'd17)};
    endfunction

    assign class_vec_in    = mem_word(frame_id, frame_index);
    assign cl_class_vec_in = mem_word(cl_frame_id, cl_frame_index);

    class_hvec_scan_ctrl u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .abort           (abort),
        .class_limit     (class_limit),
        .busy            (busy),
        .done            (done),
        .frame_id        (frame_id),
        .frame_index     (frame_index),
        .class_vec_in    (class_vec_in),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_class_id    (out_class_id),
        .out_frame_index (out_frame_index),
        .out_class_last  (out_class_last),
        .out_scan_last   (out_scan_last)
    );

    // A 3-bit limit cannot exceed 7, so the clamp is exercised on a 5-class instance.
    class_hvec_scan_ctrl #(
        .NUM_CLASSES (ClampClasses)
    ) u_dut_clamp (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (cl_start),
        .abort           (cl_abort),
        .class_limit     (cl_class_limit),
        .busy            (cl_busy),
        .done            (cl_done),
        .frame_id        (cl_frame_id),
        .frame_index     (cl_frame_index),
        .class_vec_in    (cl_class_vec_in),
        .out_data        (cl_out_data),
        .out_valid       (cl_out_valid),
        .out_ready       (cl_out_ready),
        .out_class_id    (cl_out_class_id),
        .out_frame_index (cl_out_frame_index),
        .out_class_last  (cl_out_class_last),
        .out_scan_last   (cl_out_scan_last)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] cur_tag();
        return {out_class_id, out_frame_index, out_class_last, out_scan_last};
    endfunction

    function automatic logic rdy(input int mode, input int k);
        if (mode == 0) return 1'b1;
        return (k % 4 == 1) || (k % 4 == 0);
    endfunction

    task automatic push_scan(input int lim);
        beat_t b;
        for (int c = 0; c <= lim; c++) begin
            for (int f = 0; f < NumFrames; f++) begin
                b.data = mem_word(ClsW'(c), FrmW'(f));
                b.cls  = ClsW'(c);
                b.frm  = FrmW'(f);
                b.cl   = (f == NumFrames - 1);
                b.sl   = (c == lim) && (f == NumFrames - 1);
                sb_q.push_back(b);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_data"}, out_data, 64'd0);
        check({tag, "_addr"}, 64'({frame_id, frame_index}), 64'd0);
        check({tag, "_tags"}, 64'(cur_tag()), 64'd0);
    endtask

    // rmode: 0 = ready held high, 1 = 1,0,0,1 pattern. abort_beat / busy_start_k: 0 = unused.
    task automatic run_scan(input int lim, input int rmode, input int abort_beat,
                            input int busy_start_k, input int exp_done_k);
        int          beats, last_hs, done_k;
        logic        stalled;
        logic [63:0] held_data;
        logic [6:0]  held_tag;
        beat_t       b;

        @(posedge clk); #1;
        start = 1'b1;
        class_limit = ClsW'(lim);
        out_ready = rdy(rmode, 1);
        push_scan(lim);
        @(posedge clk); #1;
        start = 1'b0;
        beats = 0; last_hs = 0; done_k = 0; stalled = 1'b0;
        held_data = '0; held_tag = '0;

        for (int k = 1; k <= 300 && done_k == 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("first_busy", 64'(busy), 64'd1);
                check("first_valid", 64'(out_valid), 64'd1);
            end
            if (stalled) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_data", out_data, held_data);
                check("stall_tag", 64'(cur_tag()), 64'(held_tag));
            end
            if (out_valid && out_ready) begin
                check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    b = sb_q.pop_front();
                    check("beat_data", out_data, b.data);
                    check("beat_tag", 64'(cur_tag()), 64'({b.cls, b.frm, b.cl, b.sl}));
                end
                beats++;
                last_hs = k;
                if (beats == abort_beat) abort = 1'b1;
            end
            stalled   = out_valid && !out_ready;
            held_data = out_data;
            held_tag  = cur_tag();
            if (done) begin
                done_k = k;
                check("done_busy_low", 64'(busy), 64'd0);
            end
            @(posedge clk); #1;
            if (abort) begin
                abort = 1'b0;
                @(negedge clk);
                check("abort_valid", 64'(out_valid), 64'd0);
                check("abort_busy", 64'(busy), 64'd0);
                for (int j = 0; j < 3; j++) begin
                    check("abort_no_done", 64'(done), 64'd0);
                    @(negedge clk);
                end
                sb_q.delete();
                out_ready = 1'b1;
                return;
            end
            if (k == busy_start_k) begin
                start = 1'b1;
                class_limit = ClsW'(2);
            end else begin
                start = 1'b0;
            end
            out_ready = rdy(rmode, k + 1);
        end

        check("done_seen", 64'(done_k != 0), 64'd1);
        check("beat_count", 64'(beats), 64'((lim + 1) * NumFrames));
        check("done_after_last", 64'(done_k), 64'(last_hs + 1));
        if (exp_done_k > 0) check("done_cycle", 64'(done_k), 64'(exp_done_k));
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        @(negedge clk);
        check("done_pulse", 64'(done), 64'd0);
        out_ready = 1'b1;
    endtask

    initial begin
        int cl_beats, cl_done_k;

        rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; class_limit = '0; out_ready = 1'b1;
        cl_start = 1'b0; cl_abort = 1'b0; cl_class_limit = '0; cl_out_ready = 1'b1;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_scan(7, 0, 0, 0, 25);   // full scan
        run_scan(0, 0, 0, 0, 4);    // single class
        run_scan(7, 1, 0, 0, 0);    // backpressure
        run_scan(7, 0, 10, 0, 0);   // abort on beat 10
        run_scan(1, 0, 0, 0, 7);    // restart after abort
        run_scan(7, 0, 0, 5, 25);   // start while busy is ignored

        // Asynchronous reset between edges mid-scan.
        @(posedge clk); #1;
        start = 1'b1; class_limit = ClsW'(7);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        check("pre_reset_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_valid", 64'(out_valid), 64'd0);
        run_scan(0, 0, 0, 0, 4);

        // Clamp: limit 7 on a 5-class instance scans classes 0..4.
        @(posedge clk); #1;
        cl_start = 1'b1; cl_class_limit = ClsW'(7);
        @(posedge clk); #1;
        cl_start = 1'b0;
        cl_beats = 0; cl_done_k = 0;
        for (int k = 1; k <= 100 && cl_done_k == 0; k++) begin
            @(negedge clk);
            if (cl_out_valid && cl_out_ready) begin
                check("clamp_cls", 64'(cl_out_class_id), 64'(cl_beats / NumFrames));
                check("clamp_frm", 64'(cl_out_frame_index), 64'(cl_beats % NumFrames));
                check("clamp_data", cl_out_data,
                      mem_word(ClsW'(cl_beats / NumFrames), FrmW'(cl_beats % NumFrames)));
                check("clamp_scan_last", 64'(cl_out_scan_last),
                      64'(cl_beats == ClampClasses * NumFrames - 1));
                cl_beats++;
            end
            if (cl_done) cl_done_k = k;
        end
        check("clamp_beats", 64'(cl_beats), 64'(ClampClasses * NumFrames));
        check("clamp_done_cycle", 64'(cl_done_k), 64'(ClampClasses * NumFrames + 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
